// File: rtl/def_useq.sv
// Shared definitions for the parametrised microsequencer: sequencing commands,
// microcode entry points and the RISC-V opcodes the dispatch logic decodes.
package def_useq;

  typedef enum logic [2:0] {
    SEQ_RESET             = 3'd0,
    SEQ_INCREMENT         = 3'd1,
    SEQ_DISPATCH_ID       = 3'd2,
    SEQ_DISPATCH_MEM_ADDR = 3'd3,
    SEQ_DISPATCH_B_CHECK  = 3'd4,
    SEQ_JUMP              = 3'd5,
    SEQ_CALL              = 3'd6,
    SEQ_RETURN            = 3'd7
  } seq_ctrl_e;

  // Micro-addresses are kept as ints so each user can size them to UPC_WIDTH.
  localparam int UINSTR_PC_IF           = 0;
  localparam int UINSTR_PC_ID           = 1;
  localparam int UINSTR_PC_MEM_ADDR     = 2;
  localparam int UINSTR_PC_LD_MEM_READ  = 3;
  localparam int UINSTR_PC_LD_WB        = 4;
  localparam int UINSTR_PC_SD_MEM_WRITE = 5;
  localparam int UINSTR_PC_REX          = 6;
  localparam int UINSTR_PC_IEX          = 7;
  localparam int UINSTR_PC_RWB          = 8;
  localparam int UINSTR_PC_B_CHECK      = 9;
  localparam int UINSTR_PC_BRANCH       = 10;
  localparam int UINSTR_PC_JAL          = 11;
  localparam int UINSTR_PC_JALR         = 12;
  localparam int UINSTR_PC_NOP          = 13;
  localparam int UINSTR_PC_HALT         = 14;

  localparam logic [6:0] OPC_ARITH     = 7'b0110011;
  localparam logic [6:0] OPC_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_ECALL     = 7'b1110011;

endpackage

// File: rtl/useq_param_if.sv
// Bundle between microcode ROM/datapath and the microsequencer.
// is_halted exists only when USEQ_ECALL_HALT_EN is defined.
interface useq_param_if #(
  parameter int UPC_WIDTH = 4,
  parameter int CNT_WIDTH = 32
);
  logic [6:0]           opcode;
  logic                 bcond;
  logic                 mem_busy;
  logic [2:0]           seq_control;
  logic [UPC_WIDTH-1:0] target_upc;
  logic [UPC_WIDTH-1:0] upc;
  logic                 instr_retired;
  logic [CNT_WIDTH-1:0] retired_cnt;
  logic                 stack_err;
`ifdef USEQ_ECALL_HALT_EN
  logic                 is_halted;

  modport master (
    output opcode, bcond, mem_busy, seq_control, target_upc,
    input  upc, instr_retired, retired_cnt, stack_err, is_halted
  );
  modport slave (
    input  opcode, bcond, mem_busy, seq_control, target_upc,
    output upc, instr_retired, retired_cnt, stack_err, is_halted
  );
`else
  modport master (
    output opcode, bcond, mem_busy, seq_control, target_upc,
    input  upc, instr_retired, retired_cnt, stack_err
  );
  modport slave (
    input  opcode, bcond, mem_busy, seq_control, target_upc,
    output upc, instr_retired, retired_cnt, stack_err
  );
`endif
endinterface

// File: rtl/useq_dispatch_rom.sv
// Combinational dispatch table: (opcode, bcond, seq_control) -> micro-address.
// With USEQ_ECALL_HALT_EN, ECALL dispatches to HALT instead of NOP.
module useq_dispatch_rom
  import def_useq::*;
#(
  parameter int UPC_WIDTH = 4
) (
  input  logic [6:0]           opcode_i,
  input  logic                 bcond_i,
  input  seq_ctrl_e            seq_control_i,
  output logic [UPC_WIDTH-1:0] target_o
);

  always_comb begin
    target_o = UPC_WIDTH'(UINSTR_PC_IF);
    unique case (seq_control_i)
      SEQ_DISPATCH_ID: begin
        unique case (opcode_i)
          OPC_ARITH:            target_o = UPC_WIDTH'(UINSTR_PC_REX);
          OPC_ARITH_IMM:        target_o = UPC_WIDTH'(UINSTR_PC_IEX);
          OPC_LOAD, OPC_STORE:  target_o = UPC_WIDTH'(UINSTR_PC_MEM_ADDR);
          OPC_BRANCH:           target_o = UPC_WIDTH'(UINSTR_PC_B_CHECK);
          OPC_JAL:              target_o = UPC_WIDTH'(UINSTR_PC_JAL);
          OPC_JALR:             target_o = UPC_WIDTH'(UINSTR_PC_JALR);
`ifdef USEQ_ECALL_HALT_EN
          OPC_ECALL:            target_o = UPC_WIDTH'(UINSTR_PC_HALT);
`else
          OPC_ECALL:            target_o = UPC_WIDTH'(UINSTR_PC_NOP);
`endif
          default:              target_o = UPC_WIDTH'(UINSTR_PC_IF);
        endcase
      end
      SEQ_DISPATCH_MEM_ADDR: begin
        if (opcode_i == OPC_LOAD)       target_o = UPC_WIDTH'(UINSTR_PC_LD_MEM_READ);
        else if (opcode_i == OPC_STORE) target_o = UPC_WIDTH'(UINSTR_PC_SD_MEM_WRITE);
        else                            target_o = UPC_WIDTH'(UINSTR_PC_IF);
      end
      SEQ_DISPATCH_B_CHECK: begin
        target_o = bcond_i ? UPC_WIDTH'(UINSTR_PC_BRANCH) : UPC_WIDTH'(UINSTR_PC_IF);
      end
      default: target_o = UPC_WIDTH'(UINSTR_PC_IF);
    endcase
  end

endmodule

// File: rtl/useq_param.sv
// Microsequencer: registered uPC, stall hold, micro-call/return stack and
// retired-instruction counter. Optional HALT state under USEQ_ECALL_HALT_EN.
module useq_param
  import def_useq::*;
#(
  parameter int UPC_WIDTH   = 4,
  parameter int STACK_DEPTH = 2,
  parameter int CNT_WIDTH   = 32
) (
  input logic         clk,
  input logic         reset,
  useq_param_if.slave bus
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [UPC_WIDTH-1:0] PC_IF = UPC_WIDTH'(UINSTR_PC_IF);
`ifdef USEQ_ECALL_HALT_EN
  localparam logic [UPC_WIDTH-1:0] PC_HALT = UPC_WIDTH'(UINSTR_PC_HALT);
`endif

  seq_ctrl_e            seq;
  logic [UPC_WIDTH-1:0] dispatch_tgt;
  logic [UPC_WIDTH-1:0] upc_q, upc_d;
  logic [SP_W-1:0]      sp_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 err_q;
  logic                 retired_q;
  logic                 push_en, pop_en, err_set, retire;
  // Sized to the full pointer range so the pointer indexes it without resizing.
  logic [UPC_WIDTH-1:0] stack_q [0:(1<<SP_W)-1];

  assign seq = seq_ctrl_e'(bus.seq_control);

  useq_dispatch_rom #(.UPC_WIDTH(UPC_WIDTH)) u_dispatch (
    .opcode_i      (bus.opcode),
    .bcond_i       (bus.bcond),
    .seq_control_i (seq),
    .target_o      (dispatch_tgt)
  );

  always_comb begin
    upc_d   = upc_q;
    push_en = 1'b0;
    pop_en  = 1'b0;
    err_set = 1'b0;
    unique case (seq)
      SEQ_RESET:     upc_d = PC_IF;
      SEQ_INCREMENT: upc_d = upc_q + UPC_WIDTH'(1);
      SEQ_DISPATCH_ID, SEQ_DISPATCH_MEM_ADDR, SEQ_DISPATCH_B_CHECK:
                     upc_d = dispatch_tgt;
      SEQ_JUMP:      upc_d = bus.target_upc;
      SEQ_CALL: begin
        upc_d = bus.target_upc;
        // A full stack drops the return address but the jump is still taken.
        if (sp_q == SP_W'(STACK_DEPTH)) err_set = 1'b1;
        else                            push_en = 1'b1;
      end
      SEQ_RETURN: begin
        if (sp_q == '0) begin
          upc_d   = PC_IF;
          err_set = 1'b1;
        end else begin
          upc_d  = stack_q[sp_q - SP_W'(1)];
          pop_en = 1'b1;
        end
      end
      default: upc_d = PC_IF;
    endcase
`ifdef USEQ_ECALL_HALT_EN
    if (upc_q == PC_HALT) begin
      upc_d   = PC_HALT;
      push_en = 1'b0;
      pop_en  = 1'b0;
      err_set = 1'b0;
    end
`endif
  end

`ifdef USEQ_ECALL_HALT_EN
  assign retire = !bus.mem_busy &&
                  (((upc_d == PC_IF) && (upc_q != PC_IF)) ||
                   ((upc_d == PC_HALT) && (upc_q != PC_HALT)));
`else
  assign retire = !bus.mem_busy && (upc_d == PC_IF) && (upc_q != PC_IF);
`endif

  // Control state: reset wins over stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      upc_q     <= PC_IF;
      sp_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      retired_q <= 1'b0;
    end else begin
      retired_q <= retire;
      if (!bus.mem_busy) begin
        upc_q <= upc_d;
        if (push_en) sp_q <= sp_q + SP_W'(1);
        if (pop_en)  sp_q <= sp_q - SP_W'(1);
        if (err_set) err_q <= 1'b1;
        if (retire)  cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Stack contents need no reset: the pointer alone defines what is live.
  always_ff @(posedge clk) begin
    if (!bus.mem_busy && push_en) stack_q[sp_q] <= upc_q + UPC_WIDTH'(1);
  end

  assign bus.upc           = upc_q;
  assign bus.instr_retired = retired_q;
  assign bus.retired_cnt   = cnt_q;
  assign bus.stack_err     = err_q;
`ifdef USEQ_ECALL_HALT_EN
  assign bus.is_halted     = (upc_q == PC_HALT);
`endif

endmodule

// File: tb/tb_useq_param.sv
// Directed-vector bench for useq_param (UPC_WIDTH=4, STACK_DEPTH=2, CNT_WIDTH=32).
// Exercises the HALT path when USEQ_ECALL_HALT_EN is defined.
module tb_useq_param;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  useq_param_if #(.UPC_WIDTH(4), .CNT_WIDTH(32)) bus ();

  useq_param #(.UPC_WIDTH(4), .STACK_DEPTH(2), .CNT_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [2:0] S_RST = 3'd0, S_INC = 3'd1, S_DID = 3'd2, S_DMA = 3'd3,
                         S_DBC = 3'd4, S_JMP = 3'd5, S_CALL = 3'd6, S_RET = 3'd7;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [2:0] sc, input logic [3:0] tgt);
    bus.seq_control = sc;
    bus.target_upc  = tgt;
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic [6:0] opc; logic [2:0] sc; logic [3:0] exp; } disp_t;
  disp_t dtab[8];

  initial begin
    reset = 1'b0;
    bus.opcode = 7'd0; bus.bcond = 1'b0; bus.mem_busy = 1'b1;
    bus.seq_control = S_INC; bus.target_upc = 4'd0;

    // Reset held with stall asserted
    step(S_INC, 0); step(S_INC, 0);
    chk("rst_upc", bus.upc, 0);
    chk("rst_cnt", bus.retired_cnt, 0);
    chk("rst_err", bus.stack_err, 0);
    chk("rst_ret", bus.instr_retired, 0);
    reset = 1'b1; bus.mem_busy = 1'b0;

    // LOAD flow
    step(S_INC, 0);  chk("ld_upc1", bus.upc, 1); chk("ld_ret1", bus.instr_retired, 0);
    bus.opcode = 7'b0000011;
    step(S_DID, 0);  chk("ld_upc2", bus.upc, 2); chk("ld_ret2", bus.instr_retired, 0);
    step(S_DMA, 0);  chk("ld_upc3", bus.upc, 3); chk("ld_ret3", bus.instr_retired, 0);
    step(S_INC, 0);  chk("ld_upc4", bus.upc, 4); chk("ld_ret4", bus.instr_retired, 0);
    step(S_RST, 0);  chk("ld_upc0", bus.upc, 0); chk("ld_ret5", bus.instr_retired, 1);
    chk("ld_cnt", bus.retired_cnt, 1);
    step(S_RST, 0);  chk("self_upc", bus.upc, 0); chk("self_ret", bus.instr_retired, 0);
    chk("self_cnt", bus.retired_cnt, 1);

    // Branch not taken / taken
    step(S_JMP, 9);  chk("br_jmp", bus.upc, 9);
    bus.bcond = 1'b0;
    step(S_DBC, 0);  chk("br_nt_upc", bus.upc, 0); chk("br_nt_ret", bus.instr_retired, 1);
    chk("br_nt_cnt", bus.retired_cnt, 2);
    step(S_JMP, 9);
    bus.bcond = 1'b1;
    step(S_DBC, 0);  chk("br_t_upc", bus.upc, 10); chk("br_t_ret", bus.instr_retired, 0);
    chk("br_t_cnt", bus.retired_cnt, 2);
    bus.bcond = 1'b0;

    // Stall at upc 3
    step(S_JMP, 3);
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(S_INC, 0);
      chk("stall_upc", bus.upc, 3);
      chk("stall_ret", bus.instr_retired, 0);
    end
    bus.mem_busy = 1'b0;
    step(S_INC, 0);  chk("unstall_upc", bus.upc, 4);
    bus.mem_busy = 1'b1;
    step(S_RST, 0);  chk("stall_rst_upc", bus.upc, 4); chk("stall_rst_ret", bus.instr_retired, 0);
    chk("stall_rst_cnt", bus.retired_cnt, 2);
    bus.mem_busy = 1'b0;

    // Stack: overflow then underflow
    step(S_JMP, 5);
    step(S_CALL, 8);  chk("call1_upc", bus.upc, 8);  chk("call1_err", bus.stack_err, 0);
    step(S_CALL, 11); chk("call2_upc", bus.upc, 11); chk("call2_err", bus.stack_err, 0);
    step(S_CALL, 12); chk("call3_upc", bus.upc, 12); chk("call3_err", bus.stack_err, 1);
    step(S_RET, 0);   chk("ret1_upc", bus.upc, 9);
    step(S_RET, 0);   chk("ret2_upc", bus.upc, 6);
    step(S_RET, 0);   chk("ret3_upc", bus.upc, 0);  chk("ret3_err", bus.stack_err, 1);
    chk("ret3_ret", bus.instr_retired, 1);
    chk("ret3_cnt", bus.retired_cnt, 3);

    // Increment wraps 15 -> 0 and retires
    step(S_JMP, 15);
    step(S_INC, 0);   chk("wrap_upc", bus.upc, 0); chk("wrap_cnt", bus.retired_cnt, 4);

    // Dispatch table
    dtab[0] = '{7'b0110011, S_DID, 4'd6};
    dtab[1] = '{7'b0010011, S_DID, 4'd7};
    dtab[2] = '{7'b0100011, S_DID, 4'd2};
    dtab[3] = '{7'b1100011, S_DID, 4'd9};
    dtab[4] = '{7'b1101111, S_DID, 4'd11};
    dtab[5] = '{7'b1100111, S_DID, 4'd12};
    dtab[6] = '{7'b1111111, S_DID, 4'd0};
    dtab[7] = '{7'b0100011, S_DMA, 4'd5};
    for (int i = 0; i < 8; i++) begin
      step(S_JMP, 1);
      bus.opcode = dtab[i].opc;
      step(dtab[i].sc, 0);
      chk($sformatf("disp%0d", i), bus.upc, dtab[i].exp);
    end

    // Reset mid-call discards the stack
    step(S_JMP, 5);
    step(S_CALL, 8);
    reset = 1'b0;
    step(S_INC, 0);   chk("mrst_upc", bus.upc, 0); chk("mrst_cnt", bus.retired_cnt, 0);
    chk("mrst_err", bus.stack_err, 0);
    reset = 1'b1;
    step(S_RET, 0);   chk("mrst_ret_upc", bus.upc, 0); chk("mrst_ret_err", bus.stack_err, 1);
    chk("mrst_ret_cnt", bus.retired_cnt, 0);

    // ECALL
    step(S_JMP, 1);
    bus.opcode = 7'b1110011;
    step(S_DID, 0);
`ifdef USEQ_ECALL_HALT_EN
    chk("ecall_upc", bus.upc, 14);
    chk("ecall_halt", bus.is_halted, 1);
    chk("ecall_cnt", bus.retired_cnt, 1);
    for (int i = 0; i < 8; i++) begin
      bus.mem_busy = i[0];
      step(3'(i), 4'd3);
      chk("halt_hold", bus.upc, 14);
      chk("halt_ret", bus.instr_retired, 0);
    end
    bus.mem_busy = 1'b0;
    chk("halt_cnt", bus.retired_cnt, 1);
    reset = 1'b0;
    step(S_INC, 0);   chk("halt_rst_upc", bus.upc, 0); chk("halt_rst_flag", bus.is_halted, 0);
    reset = 1'b1;
`else
    chk("ecall_upc", bus.upc, 13);
    chk("ecall_cnt", bus.retired_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/useq_param.md
Name: useq_param

Overview:
- Parametrised microsequencer for the multicycle RISC-V microcoded controller.
- Replaces combinational next-address selection with a registered uPC, a stall hold, and a micro-call/return stack.
- Keeps a retired-instruction counter.
- Sits between the microcode ROM (supplies seq_control, target_upc) and the datapath (supplies opcode, bcond, mem_busy).

Parameters:
- UPC_WIDTH, 4: width of uPC and all micro-addresses.
- STACK_DEPTH, 2: micro-return stack entries (>=1).
- CNT_WIDTH, 32: retired-instruction counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- opcode  in  7  opcode field of current IR.
- bcond  in  1  branch condition from ALU.
- mem_busy  in  1  memory not ready; freezes sequencer.
- seq_control  in  3  sequencing command of current microinstruction.
- target_upc  in  UPC_WIDTH  jump/call target from microinstruction.
- upc  out  UPC_WIDTH  current micro-address to ROM.
- instr_retired  out  1  one-cycle pulse: an instruction finished.
- retired_cnt  out  CNT_WIDTH  count of retired instructions.
- stack_err  out  1  sticky: overflow or underflow occurred.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: upc=UINSTR_PC_IF (0), stack pointer=0, instr_retired=0, retired_cnt=0, stack_err=0.
- Timing: upc is registered. next_upc is computed combinationally from the current upc and seq_control and loaded on the next clk edge, so each microinstruction takes 1 cycle.
- Stall: while mem_busy=1, upc, stack, counter and stack_err hold and instr_retired=0. Reset overrides stall.
- seq_control encodings and next_upc:
  - RESET(0): next_upc = IF.
  - INCREMENT(1): next_upc = upc+1, wrapping mod 2^UPC_WIDTH.
  - DISPATCH_ID(2): ARITH->REX, ARITH_IMM->IEX, LOAD/STORE->MEM_ADDR, BRANCH->B_CHECK, JAL->JAL, JALR->JALR, ECALL->NOP, other->IF.
  - DISPATCH_MEM_ADDR(3): LOAD->LD_MEM_READ, STORE->SD_MEM_WRITE, other->IF.
  - DISPATCH_B_CHECK(4): bcond ? BRANCH : IF.
  - JUMP(5): next_upc = target_upc.
  - CALL(6): push upc+1, then next_upc = target_upc. If the stack is full, the push is dropped, stack_err is set, and the jump still happens.
  - RETURN(7): next_upc = top of stack, then pop. If the stack is empty, next_upc = IF and stack_err is set.
- Retirement:
  - Condition: not stalled, next_upc==IF, and current upc!=IF.
  - Effect: next cycle instr_retired=1 and retired_cnt+1.
  - retired_cnt wraps at 2^CNT_WIDTH.
- Self-loop: IF->IF (seq_control=RESET while upc=IF) does not retire.
- Stack: LIFO. Pointer range 0..STACK_DEPTH. CALL and RETURN never coincide (one command per cycle).
- Reset mid-operation: any pending stack content is discarded; pointer returns to 0.
- Width: all uPC arithmetic is truncated to UPC_WIDTH.
- Micro-address constants (package): IF=0, ID=1, MEM_ADDR=2, LD_MEM_READ=3, LD_WB=4, SD_MEM_WRITE=5, REX=6, IEX=7, RWB=8, B_CHECK=9, BRANCH=10, JAL=11, JALR=12, NOP=13, HALT=14.

Optional Feature:
- Macro: USEQ_ECALL_HALT_EN.
- When defined:
  - DISPATCH_ID with ECALL gives next_upc=HALT.
  - Once upc=HALT, upc stays HALT regardless of seq_control and mem_busy until reset.
  - Entering HALT counts as one retirement.
  - Output is_halted (1 bit) = (upc==HALT).
- When undefined: ECALL dispatches to NOP, no HALT state exists, and is_halted is absent.

Decomposition:
- Shared package def_useq: seq_control encodings, UINSTR_PC_* micro-addresses, opcode constants (reused from the existing opcode definitions).
- Sub-module useq_dispatch_rom: purely combinational (opcode, bcond, seq_control) -> dispatch target.
- Top level owns the uPC register, stall logic, stack, counter and error flag.

Test Plan:
- Reset/hold: reset=0 for 2 cycles with mem_busy=1 -> upc=0, retired_cnt=0, stack_err=0.
- LOAD flow: upc 0->1 (INCREMENT), DISPATCH_ID with opcode=0000011 -> upc=2; DISPATCH_MEM_ADDR -> 3; INCREMENT -> 4; RESET -> 0. Required: instr_retired pulses once and retired_cnt=1.
- Branch: at upc=9, DISPATCH_B_CHECK with bcond=0 -> upc=0 and retire. Repeat with bcond=1 -> upc=10 and no retire.
- Stall: mem_busy=1 for 3 cycles at upc=3 with seq_control=INCREMENT -> upc stays 3. Release -> upc=4 next cycle.
- Stack, depth 2: at upc 5 CALL target=8, at upc 8 CALL target=11, at upc 11 CALL target=12.
  - Required: third push dropped and stack_err=1.
  - Then RETURN -> upc 9, RETURN -> upc 6, RETURN -> upc 0 with stack_err still 1.
- ECALL, USEQ_ECALL_HALT_EN defined: DISPATCH_ID with opcode=1110011 -> upc=14, is_halted=1. upc holds at 14 under any seq_control until reset.
